// File: rtl/po2_dot_product_arbiter.sv
// Round-robin arbiter/sequencer that shares one power-of-two dot-product engine between N requesters.
// Latency: grant -> dp_start next cycle -> res_v one cycle after the engine's dp_out_v is seen in WAIT.
// Backpressure: one job in flight; req_ready stays 0 until res_out is taken with res_ready.
//
// Ports: clk/rst (async active-high), req_v/req_a/req_ready (requester side, one-hot accept),
//        dp_a/dp_start/dp_out/dp_out_v (engine side), res_out/res_id/res_v/res_ready/res_err
//        (result side), busy (not IDLE).
// Optional feature: define PO2_DP_ARB_TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT cycles);
// without it res_err is tied low and WAIT holds until the engine answers.
module po2_dot_product_arbiter #(
   parameter int W       = 16,
   parameter int D       = 4,
   parameter int N       = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N-1:0]              req_v,
   input  logic [N*D*W-1:0]          req_a,
   output logic [N-1:0]              req_ready,
   output logic [D*W-1:0]            dp_a,
   output logic                      dp_start,
   input  logic signed [2*W-1:0]     dp_out,
   input  logic                      dp_out_v,
   output logic signed [2*W-1:0]     res_out,
   output logic [$clog2(N)-1:0]      res_id,
   output logic                      res_v,
   input  logic                      res_ready,
   output logic                      res_err,
   output logic                      busy
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] job_id;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] cand;
   logic          gnt_any;

   // Scan from the pointer upward; N is a power of two so the IW-bit sum wraps mod N.
   // Descending loop so the last hit written is the closest one to the pointer.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = ptr + IW'(k);
         if (req_v[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign req_ready = (state == IDLE && gnt_any) ? (N'(1) << gnt_idx) : '0;
   assign busy      = (state != IDLE);

`ifdef PO2_DP_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic          err_q;
   assign res_err = err_q;
`else
   localparam int unused_timeout = TIMEOUT;
   assign res_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         job_id   <= '0;
         dp_a     <= '0;
         dp_start <= 1'b0;
         res_out  <= '0;
         res_id   <= '0;
         res_v    <= 1'b0;
`ifdef PO2_DP_ARB_TIMEOUT_EN
         cnt      <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         dp_start <= 1'b0;
         case (state)
            IDLE: begin
               // req_ready is exactly the granted bit, so gnt_any is the transfer.
               if (gnt_any) begin
                  dp_a     <= req_a[gnt_idx*D*W +: D*W];
                  job_id   <= gnt_idx;
                  ptr      <= gnt_idx + IW'(1);
                  dp_start <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               // dp_out_v seen here still belongs to the previous job; not sampled.
               state <= WAIT;
`ifdef PO2_DP_ARB_TIMEOUT_EN
               cnt   <= '0;
`endif
            end
            WAIT: begin
               if (dp_out_v) begin
                  res_out <= dp_out;
                  res_id  <= job_id;
                  res_v   <= 1'b1;
                  state   <= RESPOND;
               end
`ifdef PO2_DP_ARB_TIMEOUT_EN
               else if (cnt == CW'(TIMEOUT - 1)) begin
                  res_out <= '0;
                  res_id  <= job_id;
                  res_v   <= 1'b1;
                  err_q   <= 1'b1;
                  state   <= RESPOND;
               end else begin
                  cnt <= cnt + CW'(1);
               end
`endif
            end
            RESPOND: begin
               if (res_ready) begin
                  res_v <= 1'b0;
`ifdef PO2_DP_ARB_TIMEOUT_EN
                  err_q <= 1'b0;
`endif
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_po2_dot_product_arbiter.sv
// Bench for po2_dot_product_arbiter: directed job table, multi-cycle corner sequences
// (timeout/stall, reset mid-job) and a randomized phase against a round-robin scoreboard.
module tb_po2_dot_product_arbiter;
   localparam int W = 16, D = 4, N = 4, TIMEOUT = 16, IW = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N-1:0]           req_v, req_ready;
   logic [N*D*W-1:0]       req_a;
   logic [D*W-1:0]         dp_a;
   logic                   dp_start, dp_out_v, res_v, res_ready, res_err, busy;
   logic signed [2*W-1:0]  dp_out, res_out;
   logic [IW-1:0]          res_id;

   int pass_cnt = 0;
   int total_cnt = 0;

   po2_dot_product_arbiter #(.W(W), .D(D), .N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_v(req_v), .req_a(req_a), .req_ready(req_ready),
      .dp_a(dp_a), .dp_start(dp_start), .dp_out(dp_out), .dp_out_v(dp_out_v),
      .res_out(res_out), .res_id(res_id), .res_v(res_v), .res_ready(res_ready),
      .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Engine math: element j (element 0 in the MSBs) shifted by a per-element power of two.
   function automatic logic [2*W-1:0] dot(input logic [D*W-1:0] v);
      longint s;
      int     sh[D];
      sh = '{2, 3, 4, 3};
      s = 0;
      for (int j = 0; j < D; j++)
         s += longint'($signed(v[(D-1-j)*W +: W])) <<< sh[j];
      return s[2*W-1:0];
   endfunction

   // Engine model: clears valid on the start edge, raises it in cycle start+L (L>=2), sticky.
   int eng_lat = 0;
   int eng_cnt = 0;
   bit eng_run = 0;
   assign dp_out = dot(dp_a);
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_out_v <= 1'b0;
         eng_run  <= 1'b0;
      end else if (dp_start) begin
         dp_out_v <= 1'b0;
         eng_cnt  <= eng_lat - 1;
         eng_run  <= (eng_lat != 0);
      end else if (eng_run) begin
         if (eng_cnt <= 1) begin
            dp_out_v <= 1'b1;
            eng_run  <= 1'b0;
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Called right after a negedge with the block idle; returns at the negedge after the handshake.
   task automatic run_job(input logic [N-1:0] mask, input int lat, input int hold,
                          input int exp_id, input logic [31:0] exp_res);
      int   k;
      int   starts;
      logic stable;
      req_v = mask;
      eng_lat = lat;
      res_ready = (hold == 0);
      #1;
      check("grant", 32'(req_ready), 32'(1) << exp_id);
      @(posedge clk);
      @(negedge clk);
      check("ready_after_grant", 32'(req_ready), 0);
      check("dp_a_latched", 32'(dp_a == req_a[exp_id*D*W +: D*W]), 1);
      starts = int'(dp_start);
      k = 1;
      while (!res_v && k < 300) begin
         @(negedge clk);
         k++;
         starts += int'(dp_start);
      end
      check("start_pulses", starts, 1);
      check("latency", k, lat + 2);
      check("res_id", 32'(res_id), exp_id);
      check("res_out", res_out, exp_res);
      check("res_err", 32'(res_err), 0);
      if (hold > 0) begin
         stable = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!res_v || res_out !== exp_res || res_id !== IW'(exp_id) || req_ready != 0 || busy !== 1'b1)
               stable = 1'b0;
         end
         check("backpressure_hold", 32'(stable), 1);
         res_ready = 1'b1;
      end
      @(negedge clk);
      check("res_v_cleared", 32'(res_v), 0);
   endtask

   function automatic int model_grant(input logic [N-1:0] rv, input int p);
      for (int k = 0; k < N; k++)
         if (rv[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   typedef struct {
      logic [N-1:0] mask;
      int           lat;
      int           hold;
      int           exp_id;
      logic [31:0]  exp_res;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] res;
   } exp_t;

   vec_t tbl[10];
   exp_t expq[$];
   exp_t e;

   initial begin
      int   k, g, mptr, outstanding, done;
      logic ok;
      logic [N-1:0]   pend;
      logic [D*W-1:0] rvec;
      logic [N-1:0]   emask;

      // Requester i holds {i+1,i+2,i+3,i+4}: engine result 36*i+100.
      tbl[0] = '{4'b1111, 7, 0, 0, 32'd100};
      tbl[1] = '{4'b1111, 3, 0, 1, 32'd136};
      tbl[2] = '{4'b1111, 2, 0, 2, 32'd172};
      tbl[3] = '{4'b1111, 5, 0, 3, 32'd208};
      tbl[4] = '{4'b1111, 4, 0, 0, 32'd100};
      tbl[5] = '{4'b0101, 3, 10, 2, 32'd172};
      tbl[6] = '{4'b0101, 2, 0, 0, 32'd100};
      tbl[7] = '{4'b1000, 6, 0, 3, 32'd208};
      tbl[8] = '{4'b0110, 2, 0, 1, 32'd136};
      tbl[9] = '{4'b0011, 2, 0, 0, 32'd100};

      rst = 1'b1;
      req_v = '0;
      res_ready = 1'b0;
      req_a = '0;
      req_a[2*D*W +: D*W] = 64'h0001_0002_0003_0004;
      #12;
      check("reset_outputs", 32'({dp_a, dp_start, res_out, res_id, res_v, res_err, busy, req_ready} == 0), 1);
      @(negedge clk);
      rst = 1'b0;

      // Single job on requester 2, L=7: res_v 9 cycles after the grant edge.
      run_job(4'b0100, 7, 0, 2, 32'h64);
      req_v = '0;

      // Restart from pointer 0 and run the directed table.
      rst = 1'b1;
      for (int i = 0; i < N; i++)
         req_a[i*D*W +: D*W] = {16'(i+1), 16'(i+2), 16'(i+3), 16'(i+4)};
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      foreach (tbl[i])
         run_job(tbl[i].mask, tbl[i].lat, tbl[i].hold, tbl[i].exp_id, tbl[i].exp_res);

      // Engine never validates: requester 1 granted (pointer is 1).
      req_v = 4'b0010;
      eng_lat = 0;
      res_ready = 1'b1;
      #1;
      check("stall_grant", 32'(req_ready), 32'b0010);
      @(posedge clk);
      @(negedge clk);
      req_v = '0;
`ifdef PO2_DP_ARB_TIMEOUT_EN
      k = 1;
      while (!res_v && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("timeout_latency", k, TIMEOUT + 2);
      check("timeout_err", 32'(res_err), 1);
      check("timeout_out", res_out, 0);
      check("timeout_id", 32'(res_id), 1);
      @(negedge clk);
      check("timeout_err_clear", 32'({res_v, res_err}), 0);
      // Stall again so the reset below lands in WAIT.
      req_v = 4'b0010;
      #1;
      check("stall_grant2", 32'(req_ready), 32'b0010);
      @(posedge clk);
      @(negedge clk);
      req_v = '0;
      repeat (4) @(negedge clk);
`else
      ok = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (res_v !== 1'b0 || res_err !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      end
      check("no_timeout_hold_wait", 32'(ok), 1);
`endif

      // Reset in WAIT (pointer is 2): outputs clear at once, arbitration restarts at 0.
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_outputs", 32'({dp_a, dp_start, res_out, res_id, res_v, res_err, busy, req_ready} == 0), 1);
      repeat (2) @(negedge clk);
      check("no_res_after_reset", 32'(res_v), 0);
      rst = 1'b0;
      run_job(4'b1010, 3, 0, 1, 32'd136);

      // Randomized phase against the round-robin scoreboard.
      req_v = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pend = '0;
      mptr = 0;
      outstanding = 0;
      done = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               rvec = {$urandom, $urandom};
               req_a[i*D*W +: D*W] = rvec;
            end
         end
         req_v = pend;
         res_ready = ($urandom_range(0, 2) != 0);
         #1;
         g = (outstanding == 0) ? model_grant(req_v, mptr) : -1;
         emask = (g < 0) ? '0 : (N'(1) << g);
         check("rand_req_ready", 32'(req_ready), 32'(emask));
         if (outstanding == 0) check("rand_idle_res_v", 32'(res_v), 0);
         if (g >= 0) begin
            e.id = g;
            e.res = dot(req_a[g*D*W +: D*W]);
            expq.push_back(e);
            pend[g] = 1'b0;
            mptr = (g + 1) % N;
            outstanding = 1;
            eng_lat = $urandom_range(2, 6);
         end else if (res_v && res_ready) begin
            if (expq.size() == 0) begin
               check("rand_unexpected_result", 32'(res_v), 0);
            end else begin
               e = expq.pop_front();
               check("rand_res_id", 32'(res_id), e.id);
               check("rand_res_out", res_out, e.res);
               check("rand_res_err", 32'(res_err), 0);
               done++;
            end
            outstanding = 0;
         end
      end
      check("rand_jobs_completed", 32'(done > 100), 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/po2_dot_product_arbiter.md
# po2_dot_product_arbiter

Round-robin arbiter and sequencer sharing one power-of-two dot-product engine between N requesters (e.g. several convolution taps or channels). It accepts a D-element activation vector from one requester at a time, latches it, restarts and runs the engine, captures its result and returns it tagged with the requester index. The block sits between the layer control logic and a single engine instance, so that the engine's weight ROMs and adders are not replicated per requester.

## Interface
- `W`, 16: element width; results are 2*W.
- `D`, 4: vector length per job.
- `N`, 4: number of requesters, ≥2, power of two.
- `TIMEOUT`, 64: watchdog limit in cycles (used only with `PO2_DP_ARB_TIMEOUT_EN`).

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_v`  in  N: bit i means requester i has a job.
- `req_a`  in  N*D*W: requester i's vector at `[i*D*W +: D*W]`, element 0 in the MSBs.
- `req_ready`  out  N: one-hot accept; a job transfers on `req_v[i] & req_ready[i]`.
- `dp_a`  out  D*W: latched vector driven to the engine.
- `dp_start`  out  1: one-cycle synchronous restart/start pulse to the engine.
- `dp_out`  in  2*W: engine result, signed.
- `dp_out_v`  in  1: engine result valid; sticky until next `dp_start`.
- `res_out`  out  2*W: returned result, signed.
- `res_id`  out  $clog2(N): requester index of `res_out`.
- `res_v`  out  1: result valid.
- `res_ready`  in  1: consumer accepts result.
- `res_err`  out  1: result produced by timeout (constant 0 without macro).
- `busy`  out  1: high in any state other than IDLE.

## Operation
- Reset values: state IDLE; rr pointer 0; all outputs 0 (`dp_a`, `res_out`, `res_id` cleared as well).
- Grant: in IDLE, grant the lowest index i ≥ pointer (mod N) with `req_v[i]`. `req_ready` is combinational, nonzero only in IDLE, and at most one bit is set.
- IDLE: on a transfer, latch `req_a[i]` into `dp_a` and i into the job id. Pointer becomes (i+1) mod N. Go to ISSUE.
- ISSUE: `dp_start`=1 for exactly this cycle. Go to WAIT.
- WAIT: sample `dp_out_v` only here; `dp_out_v` during ISSUE is stale and ignored. When it is 1, register `dp_out` into `res_out` and the job id into `res_id`, set `res_v`=1, and go to RESPOND.
- RESPOND: hold `res_v`, `res_out`, `res_id` and `res_err` stable until `res_ready`. On `res_v & res_ready`, clear `res_v` and `res_err`, and go to IDLE.
- No new job is accepted before the current result is consumed. Requests not granted stay pending, and requesters must hold `req_v` and data stable.
- `dp_a` holds its value from the grant until the next grant.
- A requester whose `req_v` drops before being granted is not served; there is no penalty.
- Arithmetic: none on data. Results pass through bit-exact.

## Timing
- Grant edge at cycle t. `dp_start` is high during t+1, and WAIT starts at t+2.
- The engine clears `dp_out_v` on the edge that samples `dp_start`.
- If the engine asserts `dp_out_v` in cycle t+1+L, `res_v` is high from cycle t+2+L.
- If `res_ready` is held high, `res_v` lasts 1 cycle. The next grant can occur in the cycle after the result handshake, giving a minimum job period of L+3 cycles.
- `rst` asserted in any state forces reset values immediately (asynchronous). A job in flight is discarded and no result is emitted. After release, arbitration restarts from index 0.
- `res_ready` asserted outside RESPOND is ignored.

## Configuration
- `PO2_DP_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT, cleared on entry.
  - If it reaches `TIMEOUT` without `dp_out_v`, go to RESPOND with `res_out`=0, `res_err`=1 and `res_id` set to the job id.
  - `dp_out_v` arriving in that same cycle takes priority and gives a normal result.
- Not defined:
  - No counter; WAIT holds indefinitely.
  - `res_err` is tied to 0.

## Test plan
- Single job: only `req_v[2]`, vector {1,2,3,4}, engine model returns 0x0000_0064 with L=7.
  - `req_ready[2]` is high 1 cycle, then `dp_start` is high 1 cycle.
  - `res_v` is high with `res_out`=0x64, `res_id`=2, 9 cycles after the grant edge.
- Round-robin: all `req_v`=4'b1111 held.
  - Grant order is 0,1,2,3,0. Result ids match the order and each result is consumed before the next grant.
- Backpressure: hold `res_ready`=0 for 10 cycles after `res_v`.
  - Output is stable and `req_ready`=0 throughout.
  - The next grant comes 1 cycle after the handshake.
- Stale valid: engine keeps `dp_out_v`=1 from the previous job through ISSUE.
  - No premature `res_v`; the result comes only after the fresh `dp_out_v` in WAIT.
- Reset mid-job: assert `rst` in WAIT.
  - All outputs are 0 immediately and no `res_v` is produced.
  - After release with `req_v`=4'b1010, the first grant is id 1.
- Timeout (macro on, `TIMEOUT`=16): engine never validates.
  - `res_v`=1, `res_err`=1, `res_out`=0 after 16 WAIT cycles.
  - Macro off: block stays in WAIT and `res_err` stays 0.
